// File: rtl/spi_cfg_master.sv
// spi_cfg_master
//   SPI master used to configure ADC/DAC parts from the host register file.
//   Serialises spi_wdata MSB-first (bit [spi_rw_len] first) on a CPOL=0 sclk
//   towards one of two chip selects and, for read transfers, captures spi_sdi
//   into spi_rdata (chip 0) or spi_rdata1 (chip 1), right-aligned.
//
//   Optional feature macro: SPI_3WIRE_EN
//     defined   : reads longer than 16 bits release the shared sdio line
//                 (spi_sdio_oe = 0) after the 16-bit instruction phase.
//     undefined : spi_sdio_oe is tied to 1.
//
// Ports
//   clk, rstb          system clock, asynchronous active-low reset
//   spi_rw_len         transfer length minus one (1..32 bits)
//   spi_ch_sel         0 = csb[0] / spi_rdata, 1 = csb[1] / spi_rdata1
//   spi_d_rise_align   0: launch on sclk fall, sample on rise; 1: the reverse
//   spi_wdata          transmit word
//   spi_wr_en/rd_en    one-cycle start pulses (both together = read)
//   spi_sdi            serial data from the slave
//   spi_sclk/csb/sdo   SPI bus outputs
//   spi_sdio_oe        output enable for a shared sdio pad
//   spi_busy/done      transfer status
//   spi_rdata/rdata1   captured read data per chip
module spi_cfg_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [4:0]  spi_rw_len,
  input  logic        spi_ch_sel,
  input  logic        spi_d_rise_align,
  input  logic [31:0] spi_wdata,
  input  logic        spi_wr_en,
  input  logic        spi_rd_en,
  input  logic        spi_sdi,
  output logic        spi_sclk,
  output logic [1:0]  spi_csb,
  output logic        spi_sdo,
  output logic        spi_sdio_oe,
  output logic        spi_busy,
  output logic        spi_done,
  output logic [31:0] spi_rdata,
  output logic [31:0] spi_rdata1
);

  localparam int SETUP_CYC = CS_SETUP * CLK_DIV;
  localparam int HOLD_CYC  = CS_HOLD * CLK_DIV;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] cnt;        // cycle counter within SETUP/HOLD, or within a half-period in SHIFT
  logic [6:0]  half;       // sclk half-period index during SHIFT (0 .. 2N-1)
  logic [4:0]  len;
  logic        ch;
  logic        align;
  logic        rd;
  logic [31:0] tx;         // current bit always sits in tx[31]
  logic [31:0] rx;
  logic [5:0]  bits;       // number of bits launched onto sdo so far

  logic start, active;
  logic div_last, setup_last, hold_last, half_last;
  logic rise_evt, fall_evt, launch_evt, sample_evt;

  assign start      = spi_wr_en | spi_rd_en;
  assign active     = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign div_last   = (cnt == 16'(CLK_DIV - 1));
  assign setup_last = (cnt == 16'(SETUP_CYC - 1));
  assign hold_last  = (cnt == 16'(HOLD_CYC - 1));
  assign half_last  = (half == {1'b0, len, 1'b1});

  // sclk edges happen at half-period boundaries: even->odd is a rise, odd->even a fall.
  assign rise_evt   = (state == SHIFT) && div_last && !half[0];
  assign fall_evt   = (state == SHIFT) && div_last && half[0];
  // The closing fall of the last bit launches nothing; the last bit stays on sdo through HOLD.
  assign launch_evt = align ? rise_evt : (fall_evt && !half_last);
  assign sample_evt = align ? fall_evt : rise_evt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETUP;
      SETUP:   if (setup_last) next_state = SHIFT;
      SHIFT:   if (div_last && half_last) next_state = HOLD;
      HOLD:    if (hold_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt  <= '0;
      half <= '0;
    end else begin
      if (state == IDLE || next_state != state || (state == SHIFT && div_last))
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (state != SHIFT)
        half <= '0;
      else if (div_last)
        half <= half + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      len        <= '0;
      ch         <= 1'b0;
      align      <= 1'b0;
      rd         <= 1'b0;
      tx         <= '0;
      rx         <= '0;
      bits       <= '0;
      spi_rdata  <= '0;
      spi_rdata1 <= '0;
    end else begin
      if (state == IDLE && start) begin
        len   <= spi_rw_len;
        ch    <= spi_ch_sel;
        align <= spi_d_rise_align;
        rd    <= spi_rd_en;
        // Left-justify so bit [len] is the first one out.
        tx    <= spi_wdata << (5'd31 - spi_rw_len);
        rx    <= '0;
        // Fall-launch mode presents bit 0 from SETUP entry; rise-launch waits for the first rise.
        bits  <= spi_d_rise_align ? 6'd0 : 6'd1;
      end
      if (launch_evt) begin
        bits <= bits + 6'd1;
        if (bits != 6'd0) tx <= {tx[30:0], 1'b0};
      end
      if (sample_evt) rx <= {rx[30:0], spi_sdi};
      // Update on the edge into DONE so rdata is valid in the done cycle.
      if (state == HOLD && hold_last && rd) begin
        if (ch) spi_rdata1 <= rx;
        else    spi_rdata  <= rx;
      end
    end
  end

`ifdef SPI_3WIRE_EN
  logic oe;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      oe <= 1'b1;
    else if (state == HOLD && hold_last)
      oe <= 1'b1;
    else if (launch_evt && rd && bits == 6'd16)
      oe <= 1'b0;   // launching bit 16: instruction phase over, turn the line around
  end
  assign spi_sdio_oe = oe;
`else
  assign spi_sdio_oe = 1'b1;
`endif

  assign spi_sclk = (state == SHIFT) && half[0];
  assign spi_csb  = active ? (ch ? 2'b01 : 2'b10) : 2'b11;
  assign spi_sdo  = active && (bits != 6'd0) && tx[31];
  assign spi_busy = (state != IDLE);
  assign spi_done = (state == DONE);

endmodule

// File: tb/tb_spi_cfg_master.sv
// Testbench for spi_cfg_master: directed transfers, a scoreboard queue of
// expected per-transfer results, and a monitor that checks each done pulse.
module tb_spi_cfg_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [4:0]  spi_rw_len = '0;
  logic        spi_ch_sel = 1'b0;
  logic        spi_d_rise_align = 1'b0;
  logic [31:0] spi_wdata = '0;
  logic        spi_wr_en = 1'b0;
  logic        spi_rd_en = 1'b0;
  logic        spi_sdi = 1'b0;
  logic        spi_sclk;
  logic [1:0]  spi_csb;
  logic        spi_sdo;
  logic        spi_sdio_oe;
  logic        spi_busy;
  logic        spi_done;
  logic [31:0] spi_rdata;
  logic [31:0] spi_rdata1;

  spi_cfg_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .rstb(rstb), .spi_rw_len(spi_rw_len), .spi_ch_sel(spi_ch_sel),
    .spi_d_rise_align(spi_d_rise_align), .spi_wdata(spi_wdata), .spi_wr_en(spi_wr_en),
    .spi_rd_en(spi_rd_en), .spi_sdi(spi_sdi), .spi_sclk(spi_sclk), .spi_csb(spi_csb),
    .spi_sdo(spi_sdo), .spi_sdio_oe(spi_sdio_oe), .spi_busy(spi_busy), .spi_done(spi_done),
    .spi_rdata(spi_rdata), .spi_rdata1(spi_rdata1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] rdata1;
    logic [31:0] sdo_word;
    int          busy;
    int          rises;
    logic [1:0]  csb;
    bit          oe_low;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          errors = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_rdata1 = '0;
  bit          cur_align = 1'b0;
  logic [31:0] slave_data = '0;
  int          slave_len = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Slave: drives sdi on the launch edge so it is stable at the DUT sample edge.
  initial begin
    int  sidx;
    logic psclk, pcs;
    sidx = 0; psclk = 1'b0; pcs = 1'b1;
    forever begin
      @(negedge clk);
      if (pcs && spi_csb != 2'b11) begin
        sidx = slave_len;
        if (!cur_align) spi_sdi = slave_data[sidx];
      end else if (!cur_align && psclk && !spi_sclk) begin
        if (sidx > 0) sidx--;
        spi_sdi = slave_data[sidx];
      end else if (cur_align && !psclk && spi_sclk) begin
        spi_sdi = slave_data[sidx];
        if (sidx > 0) sidx--;
      end
      psclk = spi_sclk;
      pcs = (spi_csb == 2'b11);
    end
  end

  // Monitor: accumulates bus observations and checks them on every done pulse.
  initial begin
    int          b_cnt, r_cnt;
    logic [31:0] sdo_w;
    logic [1:0]  csb_seen;
    bit          oe_low, rise, fall;
    logic        prev;
    exp_t        e;
    b_cnt = 0; r_cnt = 0; sdo_w = '0; csb_seen = 2'b11; oe_low = 1'b0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        b_cnt = 0; r_cnt = 0; sdo_w = '0; csb_seen = 2'b11; oe_low = 1'b0;
      end else begin
        if (spi_busy) b_cnt++;
        if (spi_csb != 2'b11) csb_seen = spi_csb;
        if (!spi_sdio_oe) oe_low = 1'b1;
        rise = spi_sclk && !prev;
        fall = !spi_sclk && prev;
        if (rise) r_cnt++;
        if ((!cur_align && rise) || (cur_align && fall)) sdo_w = {sdo_w[30:0], spi_sdo};
        if (spi_done) begin
          if (q.size() == 0) begin
            tests++; errors++;
            $display("FAIL unexpected_done: got done=1 expected no transfer pending");
          end else begin
            e = q.pop_front();
            check("rdata", spi_rdata, e.rdata);
            check("rdata1", spi_rdata1, e.rdata1);
            check("sdo_word", sdo_w, e.sdo_word);
            check("busy_cycles", 32'(b_cnt), 32'(e.busy));
            check("sclk_rises", 32'(r_cnt), 32'(e.rises));
            check("csb", {30'd0, csb_seen}, {30'd0, e.csb});
            check("oe_low_seen", {31'd0, oe_low}, {31'd0, e.oe_low});
            check("oe_at_done", {31'd0, spi_sdio_oe}, 32'd1);
          end
          b_cnt = 0; r_cnt = 0; sdo_w = '0; csb_seen = 2'b11; oe_low = 1'b0;
        end
      end
      prev = spi_sclk;
    end
  end

  task automatic pulse(input bit wr, input bit rd, input bit ch, input bit align,
                       input logic [4:0] len, input logic [31:0] wdata);
    @(negedge clk);
    spi_rw_len = len; spi_ch_sel = ch; spi_d_rise_align = align; spi_wdata = wdata;
    spi_wr_en = wr; spi_rd_en = rd;
    @(negedge clk);
    spi_wr_en = 1'b0; spi_rd_en = 1'b0;
  endtask

  task automatic issue(input bit wr, input bit rd, input bit ch, input bit align,
                       input logic [4:0] len, input logic [31:0] wdata, input logic [31:0] sdata);
    exp_t        e;
    int          n;
    logic [31:0] mask;
    n = int'(len) + 1;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    cur_align = align; slave_data = sdata; slave_len = int'(len);
    if (rd) begin
      if (ch) m_rdata1 = sdata & mask;
      else    m_rdata  = sdata & mask;
    end
    e.rdata = m_rdata; e.rdata1 = m_rdata1; e.sdo_word = wdata & mask;
    e.busy = (CS_SETUP + 2 * n + CS_HOLD) * CLK_DIV + 1;
    e.rises = n;
    e.csb = ch ? 2'b01 : 2'b10;
`ifdef SPI_3WIRE_EN
    e.oe_low = rd && (n > 16);
`else
    e.oe_low = 1'b0;
`endif
    q.push_back(e);
    pulse(wr, rd, ch, align, len, wdata);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q.size() != 0 || spi_busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      tests++; errors++;
      $display("FAIL timeout: got %0d pending after %0d cycles expected 0", q.size(), k);
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic xfer(input bit wr, input bit rd, input bit ch, input bit align,
                      input logic [4:0] len, input logic [31:0] wdata, input logic [31:0] sdata);
    issue(wr, rd, ch, align, len, wdata, sdata);
    wait_idle();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sclk"}, {31'd0, spi_sclk}, 32'd0);
    check({tag, "_csb"}, {30'd0, spi_csb}, 32'd3);
    check({tag, "_sdo"}, {31'd0, spi_sdo}, 32'd0);
    check({tag, "_oe"}, {31'd0, spi_sdio_oe}, 32'd1);
    check({tag, "_busy"}, {31'd0, spi_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, spi_done}, 32'd0);
    check({tag, "_rdata"}, spi_rdata, m_rdata);
    check({tag, "_rdata1"}, spi_rdata1, m_rdata1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // wr, rd, ch, align, len, wdata, slave data
    xfer(1, 0, 0, 0, 5'd23, 32'h00A5_5AC3, 32'h0000_0000);
    $display("[TB] ch0 write len=23 align=0 done");
    xfer(0, 1, 1, 0, 5'd15, 32'h0000_8001, 32'h0000_BEEF);
    $display("[TB] ch1 read len=15 align=0 done");
    xfer(0, 1, 1, 1, 5'd15, 32'h0000_4321, 32'h0000_1234);
    $display("[TB] ch1 read len=15 align=1 (0x1234) done");
    xfer(0, 1, 1, 1, 5'd15, 32'h0000_0F0F, 32'hFFFF_BEEF);
    $display("[TB] ch1 read len=15 align=1 (0xBEEF) done");
    xfer(1, 0, 1, 1, 5'd23, 32'h00C3_3C96, 32'h0000_0000);
    $display("[TB] ch1 write len=23 align=1 done");
    xfer(1, 0, 0, 0, 5'd0, 32'h0000_0001, 32'h0000_0000);
    $display("[TB] ch0 write len=0 done");
    xfer(0, 1, 0, 1, 5'd0, 32'h0000_0000, 32'h0000_0001);
    $display("[TB] ch0 read len=0 align=1 done");
    xfer(0, 1, 0, 0, 5'd31, 32'h1357_9BDF, 32'hDEAD_BEEF);
    $display("[TB] ch0 read len=31 align=0 done");
    xfer(1, 1, 1, 0, 5'd23, 32'h0055_AA55, 32'h00A1_B2C3);
    $display("[TB] ch1 wr+rd len=23 treated as read done");

    // Start pulse during a transfer must be ignored.
    issue(0, 1, 0, 0, 5'd7, 32'h0000_00A5, 32'h0000_005C);
    repeat (40) @(negedge clk);
    pulse(1, 0, 1, 1, 5'd31, 32'hFFFF_FFFF);
    wait_idle();
    $display("[TB] mid-transfer start pulse ignored check done");

    // Asynchronous reset while shifting: no done, bus back to idle at once.
    cur_align = 1'b0; slave_data = 32'h0000_00FF; slave_len = 15;
    pulse(0, 1, 0, 0, 5'd15, 32'h0000_1111);
    repeat (30) @(negedge clk);
    check("in_shift_busy", {31'd0, spi_busy}, 32'd1);
    rstb = 1'b0;
    m_rdata = '0; m_rdata1 = '0;
    #1;
    check_idle_outputs("abort");
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset during shift done");
    xfer(0, 1, 0, 0, 5'd23, 32'h00F0_0F0F, 32'h0012_3456);
    $display("[TB] clean read after reset done");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
